basic_full_adder: RTL and testbench
===================================

// Module: basic_full_adder
// PURPOSE
//  - 1-bit full adder: a + b + c_in -> {c_out, sum}, available combinationally with zero latency.
//  - Also provides a registered copy of the result with a valid strobe, plus a saturating
//    counter of carry-producing additions.
//  - Leaf arithmetic cell used in ripple adders and for bring-up/teaching.
//  - The combinational path must work with clk/rst_n unconnected.
// PARAMETERS
//  - CNT_W   default 8   width of carry_cnt; saturates at 2**CNT_W-1
// PORTS
//  - clk        in   1      rising-edge clock, single clock domain
//  - rst_n      in   1      synchronous, active-low reset
//  - a          in   1      addend bit
//  - b          in   1      addend bit
//  - c_in       in   1      carry in
//  - in_valid   in   1      qualifies a/b/c_in for the registered path
//  - sum        out  1      combinational sum = a ^ b ^ c_in
//  - c_out      out  1      combinational carry = (a&b) | (c_in&(a^b))
//  - sum_q      out  1      registered sum
//  - c_out_q    out  1      registered carry
//  - out_valid  out  1      registered in_valid (1-cycle strobe per accepted input)
//  - carry_cnt  out  CNT_W  count of accepted additions with c_out=1
// BEHAVIOUR
//  - Clock/reset: one clock, clk; rst_n synchronous, active-low, sampled on the rising clk edge.
//  - sum/c_out: purely combinational, no dependence on clk/rst_n.
//    - Truth table (a b c_in -> sum c_out):
//      000->00, 001->10, 010->10, 011->01, 100->10, 101->01, 110->01, 111->11.
//    - Any input change is reflected within the same delta/settle time.
//  - Reset (rst_n=0 at posedge): sum_q=0, c_out_q=0, out_valid=0, carry_cnt=0.
//    - Reset wins over in_valid in the same cycle.
//  - Normal posedge with rst_n=1:
//    - out_valid <= in_valid.
//    - If in_valid: sum_q <= sum, c_out_q <= c_out; otherwise sum_q/c_out_q hold.
//    - If in_valid && c_out && carry_cnt != max: carry_cnt <= carry_cnt+1.
//    - At max, carry_cnt holds (saturates, no wrap).
//  - Latency: combinational path 0 cycles; registered path 1 cycle.
//    - Back-to-back in_valid is accepted every cycle; no backpressure.
//  - Reset mid-stream: the in-flight result is discarded; out_valid=0 in the cycle after reset.
//  - X on a/b/c_in with in_valid=0 must not corrupt the registered state.
// STRUCTURE
//  - Package fa_pkg:
//    - localparam FA_CNT_W_DEFAULT = 8.
//    - typedef struct packed {logic c; logic s;} fa_res_t.
//  - Sub-module half_adder (x, y -> s = x^y, c = x&y).
//    - Instantiated twice: ha0(a,b), ha1(ha0.s,c_in).
//    - sum = ha1.s; c_out = ha0.c | ha1.c.
//  - Top: one always_ff block for the output register, valid flag and saturating counter;
//    the combinational outputs come from the continuous assignments.
// TESTING
//  - Exhaustive 8-vector sweep of a/b/c_in, 100 time units each, clk idle:
//    sum/c_out match the truth table above.
//  - rst_n=0 for 2 cycles with in_valid=1, a=b=c_in=1:
//    sum_q=0, c_out_q=0, out_valid=0, carry_cnt=0.
//  - After reset, in_valid=1 with a=1, b=1, c_in=0 for one cycle:
//    next cycle sum_q=0, c_out_q=1, out_valid=1, carry_cnt=1; the following cycle out_valid=0.
//  - Stream all 8 vectors back-to-back with in_valid=1:
//    registered outputs trail by 1 cycle and carry_cnt increments by 4.
//  - CNT_W=2 with 5 carry-producing inputs: carry_cnt reaches 3 and holds at 3.
//  - Assert rst_n=0 during a stream: the next cycle shows out_valid=0 and carry_cnt=0,
//    and the stream resumes cleanly after release.

Source files
------------

// File: rtl/fa_pkg.sv
// Shared definitions for the basic full adder cell: the default counter width
// and the packed {carry, sum} result type.
package fa_pkg;

   localparam int FA_CNT_W_DEFAULT = 8;

   typedef struct packed {
      logic c;
      logic s;
   } fa_res_t;

endpackage : fa_pkg

// File: rtl/basic_full_adder_half_adder.sv
// Half adder leaf: two-bit sum and carry. Two of these make a full adder.
module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);

   assign s = x ^ y;
   assign c = x & y;

endmodule : half_adder

// File: rtl/basic_full_adder.sv
// 1-bit full adder with a zero-latency combinational result, a registered copy
// qualified by in_valid, and a saturating count of carry-producing additions.
module basic_full_adder
   import fa_pkg::*;
#(
   parameter int CNT_W = FA_CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             c_in,
   input  logic             in_valid,
   output logic             sum,
   output logic             c_out,
   output logic             sum_q,
   output logic             c_out_q,
   output logic             out_valid,
   output logic [CNT_W-1:0] carry_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic    ha0_s;
   logic    ha0_c;
   logic    ha1_s;
   logic    ha1_c;
   fa_res_t res;
   fa_res_t res_q;

   half_adder ha0 (
      .x (a),
      .y (b),
      .s (ha0_s),
      .c (ha0_c)
   );

   half_adder ha1 (
      .x (ha0_s),
      .y (c_in),
      .s (ha1_s),
      .c (ha1_c)
   );

   // The combinational result never touches clk/rst_n, so it works with both unconnected.
   assign res   = '{c: ha0_c | ha1_c, s: ha1_s};
   assign sum   = res.s;
   assign c_out = res.c;

   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_q     <= '0;
         out_valid <= 1'b0;
         carry_cnt <= '0;
      end else begin
         out_valid <= in_valid;
         // Everything below is gated by in_valid, so unknown operands on idle cycles cannot leak in.
         if (in_valid) begin
            res_q <= res;
            if (res.c && (carry_cnt != CNT_MAX)) begin
               carry_cnt <= carry_cnt + CNT_W'(1);
            end
         end
      end
   end

   assign sum_q   = res_q.s;
   assign c_out_q = res_q.c;

endmodule : basic_full_adder

// File: tb/tb_basic_full_adder.sv
// Self-checking bench for basic_full_adder: truth-table sweep, directed
// register/reset/saturation sequences and a randomized run against a model.
module tb_basic_full_adder;

   typedef struct {
      logic a;
      logic b;
      logic c_in;
      logic sum;
      logic c_out;
   } vec_t;

   logic       clk;
   logic       clk_en;
   logic       rst_n;
   logic       a;
   logic       b;
   logic       c_in;
   logic       in_valid;
   logic       sum;
   logic       c_out;
   logic       sum_q;
   logic       c_out_q;
   logic       out_valid;
   logic [7:0] carry_cnt;
   logic       sum_s;
   logic       c_out_s;
   logic       sum_q_s;
   logic       c_out_q_s;
   logic       out_valid_s;
   logic [1:0] carry_cnt_s;

   int vectors;
   int miscompares;

   // Reference model state
   int m_sum_q;
   int m_c_q;
   int m_valid;
   int m_cnt8;
   int m_cnt2;

   basic_full_adder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .in_valid  (in_valid),
      .sum       (sum),
      .c_out     (c_out),
      .sum_q     (sum_q),
      .c_out_q   (c_out_q),
      .out_valid (out_valid),
      .carry_cnt (carry_cnt)
   );

   basic_full_adder #(.CNT_W(2)) dut_sat (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .in_valid  (in_valid),
      .sum       (sum_s),
      .c_out     (c_out_s),
      .sum_q     (sum_q_s),
      .c_out_q   (c_out_q_s),
      .out_valid (out_valid_s),
      .carry_cnt (carry_cnt_s)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = clk_en ? ~clk : 1'b0;
   end

   task automatic check(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
      end
   endtask

   task automatic check_model();
      check("sum_q",       int'(sum_q),       m_sum_q);
      check("c_out_q",     int'(c_out_q),     m_c_q);
      check("out_valid",   int'(out_valid),   m_valid);
      check("carry_cnt",   int'(carry_cnt),   m_cnt8);
      check("sat_cnt",     int'(carry_cnt_s), m_cnt2);
      check("sat_valid",   int'(out_valid_s), m_valid);
   endtask

   // Apply one cycle of stimulus, check the combinational result before the
   // edge and the registered state just after it.
   task automatic step(input logic ta, input logic tb_in, input logic tc,
                       input logic tiv, input logic trn);
      int total;
      a        = ta;
      b        = tb_in;
      c_in     = tc;
      in_valid = tiv;
      rst_n    = trn;
      total    = int'(ta) + int'(tb_in) + int'(tc);
      #1;
      check("sum",   int'(sum),   total % 2);
      check("c_out", int'(c_out), total / 2);
      @(posedge clk);
      if (!trn) begin
         m_sum_q = 0;
         m_c_q   = 0;
         m_valid = 0;
         m_cnt8  = 0;
         m_cnt2  = 0;
      end else begin
         m_valid = int'(tiv);
         if (tiv) begin
            m_sum_q = total % 2;
            m_c_q   = total / 2;
            if (total >= 2) begin
               m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
               m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
            end
         end
      end
      #1;
      check_model();
   endtask

   initial begin
      vec_t tbl[8];
      int   cnt_before;

      vectors     = 0;
      miscompares = 0;
      clk_en      = 1'b0;
      rst_n       = 1'b1;
      in_valid    = 1'b0;
      a           = 1'b0;
      b           = 1'b0;
      c_in        = 1'b0;
      m_sum_q     = 0;
      m_c_q       = 0;
      m_valid     = 0;
      m_cnt8      = 0;
      m_cnt2      = 0;

      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      // Combinational sweep with the clock idle
      for (int i = 0; i < 8; i++) begin
         a    = tbl[i].a;
         b    = tbl[i].b;
         c_in = tbl[i].c_in;
         #100;
         check("tt_sum",   int'(sum),   int'(tbl[i].sum));
         check("tt_c_out", int'(c_out), int'(tbl[i].c_out));
      end

      clk_en = 1'b1;
      @(negedge clk);

      // Reset for two cycles while presenting a carry-producing valid input
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      check("rst_sum_q",     int'(sum_q),     0);
      check("rst_c_out_q",   int'(c_out_q),   0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_carry_cnt", int'(carry_cnt), 0);

      // Single accepted add, then an idle cycle
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      check("one_sum_q",     int'(sum_q),     0);
      check("one_c_out_q",   int'(c_out_q),   1);
      check("one_out_valid", int'(out_valid), 1);
      check("one_carry_cnt", int'(carry_cnt), 1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check("one_strobe_end", int'(out_valid), 0);
      check("one_hold_c_q",   int'(c_out_q),   1);

      // Back-to-back stream of all eight vectors
      cnt_before = int'(carry_cnt);
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].a, tbl[i].b, tbl[i].c_in, 1'b1, 1'b1);
         check("strm_sum_q", int'(sum_q),   int'(tbl[i].sum));
         check("strm_c_q",   int'(c_out_q), int'(tbl[i].c_out));
      end
      check("strm_cnt_delta", int'(carry_cnt) - cnt_before, 4);

      // Saturation of the narrow counter
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      check("sat_at_max", int'(carry_cnt_s), 3);
      check("wide_cnt5",  int'(carry_cnt),   5);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      check("sat_holds",  int'(carry_cnt_s), 3);

      // Reset in the middle of a stream, then resume
      step(0, 1, 1, 1'b1, 1'b1);
      step(1, 1, 0, 1'b1, 1'b0);
      check("mid_rst_valid", int'(out_valid), 0);
      check("mid_rst_cnt",   int'(carry_cnt), 0);
      step(1, 0, 1, 1'b1, 1'b1);
      check("resume_valid", int'(out_valid), 1);
      check("resume_cnt",   int'(carry_cnt), 1);
      check("resume_c_q",   int'(c_out_q),   1);

      // Randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         step(1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_basic_full_adder
